// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

  localparam int unsigned NREQ_DEF = 2;
  localparam int unsigned CMD_W    = 3;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CMD_W-1:0] XOR  = 3'b001;
  localparam logic [CMD_W-1:0] BNE  = 3'b010;
  localparam logic [CMD_W-1:0] ADD  = 3'b011;
  localparam logic [CMD_W-1:0] LSH  = 3'b100;
  localparam logic [CMD_W-1:0] RSH  = 3'b101;
  localparam logic [CMD_W-1:0] SELB = 3'b110;
  localparam logic [CMD_W-1:0] NOP  = 3'b111;

  // Operands latched for the granted requester.
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sc;
  } alu_op_t;

  // Registered response slot.
  typedef struct packed {
    logic [DATA_W-1:0] rslt;
    logic              sc;
    logic              pari;
    logic              br;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: lowest valid index at or above rr_ptr, wrapping.
module rr_picker
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  gnt,
  output logic            any_valid
);

  // First pass covers indices from the pointer upward, second pass wraps.
  always_comb begin
    gnt       = '0;
    any_valid = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!any_valid && req_valid[j] && (IDW'(j) >= rr_ptr)) begin
        any_valid = 1'b1;
        gnt       = IDW'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!any_valid && req_valid[j]) begin
        any_valid = 1'b1;
        gnt       = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Optional ALU_ARB_LOCK_EN adds req_lock for back-to-back grants to one owner.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned A    = CMD_W,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*A-1:0] req_cmd,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ-1:0]   req_sc,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [7:0]        rsp_rslt,
  output logic              rsp_sc,
  output logic              rsp_pari,
  output logic              rsp_br,
  output logic [A-1:0]      alu_cmd,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_sc,
  input  logic [7:0]        alu_rslt,
  input  logic              alu_sco,
  input  logic              alu_br
);

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  alu_op_t        op_q, op_d, op_sel;
  alu_rsp_t       rsp_q, rsp_d;

  logic [IDW-1:0] pick_gnt;
  logic           pick_any;
  logic           rsp_ack;
  logic           lock_hold;
  logic [IDW-1:0] next_id;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt       (pick_gnt),
    .any_valid (pick_any)
  );

  assign next_id = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  // Mux the picked requester's operands and the owner's response-side controls.
  always_comb begin
    op_sel    = '0;
    rsp_ack   = 1'b0;
    lock_hold = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt == IDW'(i)) begin
        op_sel.cmd = CMD_W'(req_cmd[i*A +: A]);
        op_sel.a   = req_a[i*8 +: 8];
        op_sel.b   = req_b[i*8 +: 8];
        op_sel.sc  = req_sc[i];
      end
      if (gnt_id_q == IDW'(i)) begin
        rsp_ack = rsp_ready[i];
`ifdef ALU_ARB_LOCK_EN
        lock_hold = req_lock[i];
`endif
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    rsp_d     = rsp_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = NREQ'(1) << pick_gnt;
          op_d      = op_sel;
          gnt_id_d  = pick_gnt;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_d.rslt = alu_rslt;
        rsp_d.sc   = alu_sco;
        rsp_d.pari = ^alu_rslt;
        // Branch flag is only meaningful for BNE.
        rsp_d.br   = (op_q.cmd == BNE) && alu_br;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = NREQ'(1) << gnt_id_q;
        if (rsp_ack) begin
          state_d  = IDLE;
          rr_ptr_d = lock_hold ? gnt_id_q : next_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      op_q     <= '{cmd: NOP, a: '0, b: '0, sc: 1'b0};
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      rsp_q    <= rsp_d;
    end
  end

  assign alu_cmd  = A'(op_q.cmd);
  assign alu_a    = op_q.a;
  assign alu_b    = op_q.b;
  assign alu_sc   = op_q.sc;
  assign rsp_rslt = rsp_q.rslt;
  assign rsp_sc   = rsp_q.sc;
  assign rsp_pari = rsp_q.pari;
  assign rsp_br   = rsp_q.br;

endmodule
